// File: rtl/fifo_read_ctrl.sv
// fifo_read_ctrl: read-domain side of the async FIFO.
// Shares one FIFO read port between two consumers with a round-robin arbiter.
// Owns the binary and Gray read pointers and the empty flag.
// Brings the write-domain Gray pointer across with a two-flop synchroniser.
// Reports a read-side fill estimate and returns registered pop data to the consumer that was granted.
`timescale 1ns/1ps

module fifo_read_ctrl #(
  parameter int ADD_SIZE = 3,
  parameter int DATA_W   = 8
) (
  input  logic              i_r_clk,
  input  logic              i_rst,
  input  logic              i_req0,
  input  logic              i_req1,
  input  logic              i_flush,
  input  logic [ADD_SIZE:0] i_wptr_gray,
  input  logic [DATA_W-1:0] i_r_data,
  output logic              o_r_en,
  output logic [ADD_SIZE:0] o_r_add,
  output logic [ADD_SIZE:0] o_rptr_gray,
  output logic              o_empty,
  output logic [ADD_SIZE:0] o_rd_level,
  output logic              o_gnt0,
  output logic              o_gnt1,
  output logic [DATA_W-1:0] o_dout,
  output logic              o_dvalid0,
  output logic              o_dvalid1
);

  localparam int PW = ADD_SIZE + 1;

  // Gray to binary: each binary bit is the XOR of all Gray bits at and above it.
  function automatic logic [PW-1:0] f_g2b(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PW-1:0]     r_wq1;
  logic [PW-1:0]     r_wq2;
  logic [PW-1:0]     r_add;
  logic [PW-1:0]     r_rptr_gray;
  logic              r_empty;
  logic [PW-1:0]     r_rd_level;
  logic [DATA_W-1:0] r_dout;
  logic              r_dvalid0;
  logic              r_dvalid1;
  // 1 = consumer 1 was granted last, so consumer 0 wins the next tie.
  logic              r_last_gnt;

  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_r_en;
  logic [PW-1:0]     w_wq2_bin;
  logic [PW-1:0]     w_next_bin;
  logic [PW-1:0]     w_next_gray;

  // Two-flop synchroniser; r_wq1 is the only flop that samples i_wptr_gray.
  always_ff @(posedge i_r_clk) begin
    if (i_rst) begin
      r_wq1 <= '0;
      r_wq2 <= '0;
    end else begin
      r_wq1 <= i_wptr_gray;
      r_wq2 <= r_wq1;
    end
  end

  // Round-robin arbiter. It works only from registered state, and it gives no grant while the FIFO is empty or being flushed.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!r_empty && !i_flush) begin
      if (i_req0 && i_req1) begin
        if (r_last_gnt) begin
          w_gnt0 = 1'b1;
        end else begin
          w_gnt1 = 1'b1;
        end
      end else if (i_req0) begin
        w_gnt0 = 1'b1;
      end else if (i_req1) begin
        w_gnt1 = 1'b1;
      end
    end
  end

  assign w_r_en = w_gnt0 | w_gnt1;

  // Next read pointer. A flush jumps it to the synchronised write pointer, which discards everything visible so far.
  always_comb begin
    w_wq2_bin = f_g2b(r_wq2);
    if (i_flush) begin
      w_next_bin = w_wq2_bin;
    end else begin
      w_next_bin = r_add + {{ADD_SIZE{1'b0}}, w_r_en};
    end
    w_next_gray = w_next_bin ^ (w_next_bin >> 1);
  end

  // Pointer, empty flag and level registers; they are all computed from the next pointer value.
  always_ff @(posedge i_r_clk) begin
    if (i_rst) begin
      r_add       <= '0;
      r_rptr_gray <= '0;
      r_empty     <= 1'b1;
      r_rd_level  <= '0;
    end else begin
      r_add       <= w_next_bin;
      r_rptr_gray <= w_next_gray;
      r_empty     <= i_flush | (w_next_gray == r_wq2);
      r_rd_level  <= i_flush ? '0 : (w_wq2_bin - w_next_bin);
    end
  end

  // Capture popped data and route the valid strobe to the port that was granted.
  always_ff @(posedge i_r_clk) begin
    if (i_rst) begin
      r_dout     <= '0;
      r_dvalid0  <= 1'b0;
      r_dvalid1  <= 1'b0;
      r_last_gnt <= 1'b1;
    end else begin
      r_dvalid0 <= w_gnt0;
      r_dvalid1 <= w_gnt1;
      if (w_r_en) begin
        r_dout     <= i_r_data;
        r_last_gnt <= w_gnt1;
      end
    end
  end

  assign o_r_en      = w_r_en;
  assign o_gnt0      = w_gnt0;
  assign o_gnt1      = w_gnt1;
  assign o_r_add     = r_add;
  assign o_rptr_gray = r_rptr_gray;
  assign o_empty     = r_empty;
  assign o_rd_level  = r_rd_level;
  assign o_dout      = r_dout;
  assign o_dvalid0   = r_dvalid0;
  assign o_dvalid1   = r_dvalid1;

endmodule
